// File: rtl/muldiv_if.sv
// Handshake and result bundle between a requester and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             done_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    // acc holds the running upper half; sh is the multiplier shifting out / product low half shifting in
    sum      = acc + {1'b0, (sh[0] ? opnd : '0)};
    // restoring divide: acc is the partial remainder, sh shifts dividend out and quotient in
    shifted  = {acc[WIDTH-1:0], sh[WIDTH-1]};
    ge       = shifted >= {1'b0, opnd};
    diff     = shifted - {1'b0, opnd};
    prod     = {acc[WIDTH-1:0], sh};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -sh : sh;
    r_fix    = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001: begin
                state  <= MUL;
                cnt    <= '0;
                acc    <= '0;
                sh     <= b_mag;
                opnd   <= a_mag;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
                dz     <= 1'b0;
                is_div <= 1'b0;
              end
              3'b010, 3'b011: begin
                state  <= DIV;
                cnt    <= '0;
                acc    <= '0;
                sh     <= a_mag;
                opnd   <= b_mag;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= (bus.b == '0);
                is_div <= 1'b1;
              end
              3'b100:  hi_q <= bus.a;
              3'b101:  lo_q <= bus.a;
              default: ;
            endcase
          end
          MUL: begin
            acc <= {1'b0, sum[WIDTH:1]};
            sh  <= {sum[0], sh[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
          DIV: begin
            acc <= ge ? diff : shifted;
            sh  <= {sh[WIDTH-2:0], ge};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
          default: begin
            state  <= IDLE;
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= r_fix;
              lo_q <= dz ? '1 : q_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        endcase
      end
    end
  end

  assign bus.busy = (state == MUL) || (state == DIV);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning operand, HI and LO width; legal values are even and at least 8.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL provide port start, input, 1 bit: operation request, sampled on a rising edge.
REQ-005 SHALL provide port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes are no-ops.
REQ-006 SHALL provide port a, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 SHALL provide port b, input, WIDTH bits: multiplier or divisor.
REQ-008 SHALL provide port flush, input, 1 bit: abort in-flight operation.
REQ-009 SHALL provide port busy, output, 1 bit: iterative operation in progress.
REQ-010 SHALL provide port done, output, 1 bit: one-cycle pulse when HI/LO are updated by MULT/MULTU/DIV/DIVU.
REQ-011 SHALL provide port hi, output, WIDTH bits: HI register (product upper half or remainder).
REQ-012 SHALL provide port lo, output, WIDTH bits: LO register (product lower half or quotient).

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-014 SHALL accept start only in IDLE; start while busy is ignored and the in-flight operation is unaffected.
REQ-015 SHALL, on an accepted MULT/MULTU, capture operand magnitudes and result sign, enter MUL, and assert busy from the next cycle.
REQ-016 SHALL, in MUL, perform one shift-add step per cycle for WIDTH cycles, then enter FIX.
REQ-017 SHALL, on an accepted DIV/DIVU, capture operand magnitudes and quotient/remainder signs, then enter DIV.
REQ-018 SHALL, in DIV, perform one restoring step per cycle for WIDTH cycles, then enter FIX.
REQ-019 SHALL, in FIX, apply sign correction, write hi/lo, deassert busy, pulse done for exactly one cycle, and return to IDLE.
REQ-020 SHALL make the result latency WIDTH+1 edges after the start edge: hi, lo and done are valid in the cycle after the (WIDTH+1)th edge, with busy low in that same cycle.
REQ-021 SHALL give MULT a 2*WIDTH two's-complement product {hi,lo} and MULTU an unsigned product.
REQ-022 SHALL have DIV truncate the quotient toward zero, with the remainder taking the sign of the dividend.
REQ-023 SHALL handle divide by zero (b=0) with the full normal latency, setting lo to all ones and hi to a, for both DIV and DIVU.
REQ-024 SHALL handle signed overflow in DIV (a = most-negative value, b = -1) by setting lo to the most-negative value and hi to 0.
REQ-025 SHALL complete MTHI/MTLO from IDLE in one edge, writing hi (or lo) with a, with no busy assertion and no done pulse.
REQ-026 SHALL ignore MTHI/MTLO while busy.
REQ-027 SHALL, on flush, return to IDLE at the next edge with busy low, no done pulse, and hi/lo unchanged; flush takes priority over start in the same cycle.
REQ-028 SHALL, when flush and the FIX edge coincide, leave hi/lo unwritten and pulse no done.
REQ-029 SHALL keep hi and lo stable except on the FIX write or an MTHI/MTLO write.
REQ-030 SHALL implement the iteration counter with ceil(log2(WIDTH+1)) bits, with no wrap before FIX.

Reset
REQ-031 SHALL, on a rising edge with reset=0, force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter.
REQ-032 SHALL abort any in-flight operation on reset mid-operation, without a done pulse.
REQ-033 SHALL ignore start while reset=0.

Verification (WIDTH=32)
REQ-034 SHALL cover MULT: a=0xFFFFFFFF (-1), b=7 -> done after 33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFF9; busy high for exactly 32 cycles.
REQ-035 SHALL cover DIV: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=100, b=7 -> lo=14, hi=2.
REQ-036 SHALL cover divide by zero: DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234; overflow: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL cover start of MULTU 3x5 issued 5 cycles into a DIVU 100/7 -> only the DIVU result is written, with a single done pulse.
REQ-038 SHALL cover flush asserted at cycle 10 of a MULT with prior hi=0xA, lo=0xB -> busy low next cycle, no done, hi=0xA, lo=0xB.
REQ-039 SHALL cover reset=0 mid-DIV followed by MTLO a=0x55 -> hi=0, lo=0x55 one edge later, and done never pulses.
